// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared size encodings, FSM state type and alignment helper for the LSU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_mux.sv
// ============================================================================
// Module : lsu_lane_mux
// Brief  : Little-endian lane extraction with sign/zero extension, and lane merge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (lane_i)
            2'd0:    w_byte = rd_word_i[7:0];
            2'd1:    w_byte = rd_word_i[15:8];
            2'd2:    w_byte = rd_word_i[23:16];
            default: w_byte = rd_word_i[31:24];
        endcase
        w_half = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        case (size_i)
            SZ_BYTE: ext_o = {{24{signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: ext_o = {{16{signed_i & w_half[15]}}, w_half};
            default: ext_o = rd_word_i;
        endcase

        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = new_data_i[7:0];
                    2'd1:    merged_o[15:8]  = new_data_i[7:0];
                    2'd2:    merged_o[23:16] = new_data_i[7:0];
                    default: merged_o[31:24] = new_data_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_i[1]) merged_o[31:16] = new_data_i[15:0];
                else           merged_o[15:0]  = new_data_i[15:0];
            end
            default: merged_o = new_data_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Byte/half/word load-store front end for a word-only memory (RMW stores).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q,  state_d;
    logic        we_q,     we_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] merge_q,  merge_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic [31:0] w_ext;
    logic [31:0] w_merged;
    logic        w_err;

    lsu_lane_mux u_lane_mux (
        .rd_word_i  (mem_rd),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .signed_i   (signed_q),
        .old_word_i (merge_q),
        .new_data_i (wdata_q),
        .ext_o      (w_ext),
        .merged_o   (w_merged)
    );

    assign w_err = (req_size == SZ_RSVD)
                 | is_misaligned(req_size, req_addr[1:0])
                 | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = w_err;
                    if (w_err)                 state_d = ST_RESP;
                    else if (!req_we)          state_d = ST_LOAD;
                    else if (req_size == SZ_WORD) state_d = ST_WRITE;
                    else                       state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                rdata_d = w_ext;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merge_d = mem_rd;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with rst_n keeps a reset edge from ever committing a write.
    assign mem_we    = rst_n && (state_q == ST_WRITE);
    assign mem_addr  = (state_q == ST_IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    assign mem_wd    = (state_q != ST_WRITE) ? 32'h0 :
                       (size_q == SZ_WORD)   ? wdata_q : w_merged;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit with a behavioural word memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    int          we_cnt  = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wd;
        end
    end

    // Issues one request and returns once rsp_valid is seen (or the bound expires).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int wes);
        int we0;
        we0        = we_cnt;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_wdata  = 32'h5A5A5A5A;
        req_addr   = 32'h0000_0004;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        wes = we_cnt - we0;
    endtask

    task automatic consume();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'h1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_regs: got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
        end
        checks++;
        if (we_cnt !== 0) begin errors++; $display("FAIL reset_no_write: got %0d writes want 0", we_cnt); end
    endtask

    task automatic test_word();
        int lat, wes;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, wes);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        checks++;
        if (wes !== 1) begin errors++; $display("FAIL sw_writes: got %0d want 1", wes); end
        checks++;
        if (last_wa !== 32'd4) begin errors++; $display("FAIL sw_addr: got %h want 4", last_wa); end
        checks++;
        if (last_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", last_wd); end
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL sw_rsp: got err=%b rdata=%h want 0/0", rsp_err, rsp_rdata);
        end
        consume();

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, wes);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rsp_rdata); end
        checks++;
        if (wes !== 0) begin errors++; $display("FAIL lw_writes: got %0d want 0", wes); end
        consume();

        // Highest in-range word index.
        do_req(1'b1, 2'b10, 1'b0, 32'hFC, 32'h600DF00D, lat, wes);
        consume();
        do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, lat, wes);
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h600DF00D) begin
            errors++; $display("FAIL lw_top_word: got err=%b rdata=%h want 0/600df00d", rsp_err, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_byte_rmw();
        int lat, wes;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, wes);
        consume();
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, lat, wes);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
        checks++;
        if (wes !== 1) begin errors++; $display("FAIL sb_writes: got %0d want 1", wes); end
        checks++;
        if (last_wa !== 32'd4) begin errors++; $display("FAIL sb_addr: got %h want 4", last_wa); end
        checks++;
        if (last_wd !== 32'h11AA3344) begin errors++; $display("FAIL sb_data: got %h want 11aa3344", last_wd); end
        consume();

        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_signed: got %h want ffffffaa", rsp_rdata); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d want 2", lat); end
        consume();
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'h000000AA) begin errors++; $display("FAIL lb_unsigned: got %h want 000000aa", rsp_rdata); end
        consume();
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'h00000033) begin errors++; $display("FAIL lb_lane1: got %h want 00000033", rsp_rdata); end
        consume();
    endtask

    task automatic test_half();
        int lat, wes;
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h0000CAFE, lat, wes);
        consume();
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h12348001, lat, wes);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d want 3", lat); end
        checks++;
        if (last_wa !== 32'd5 || last_wd !== 32'h8001CAFE) begin
            errors++; $display("FAIL sh_write: got addr=%h data=%h want 5/8001cafe", last_wa, last_wd);
        end
        consume();
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed: got %h want ffff8001", rsp_rdata); end
        consume();
        do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'hFFFFCAFE) begin errors++; $display("FAIL lh_low_signed: got %h want ffffcafe", rsp_rdata); end
        consume();
        do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'h0000CAFE) begin errors++; $display("FAIL lh_unsigned: got %h want 0000cafe", rsp_rdata); end
        consume();
    endtask

    task automatic test_errors();
        int lat, wes;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin we = 1'b1; sz = 2'b01; a = 32'h13;  end
                1:       begin we = 1'b1; sz = 2'b10; a = 32'h12;  end
                2:       begin we = 1'b0; sz = 2'b11; a = 32'h10;  end
                default: begin we = 1'b1; sz = 2'b10; a = 32'h100; end
            endcase
            do_req(we, sz, 1'b1, a, 32'hFFFFFFFF, lat, wes);
            checks++;
            if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
                errors++; $display("FAIL err_rsp[%0d]: got err=%b rdata=%h want 1/0", i, rsp_err, rsp_rdata);
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
            checks++;
            if (wes !== 0) begin errors++; $display("FAIL err_writes[%0d]: got %0d want 0", i, wes); end
            consume();
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, wes);
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h11AA3344) begin
            errors++; $display("FAIL err_mem_intact: got err=%b rdata=%h want 0/11aa3344", rsp_err, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat, wes;
        rsp_ready = 1'b0;
        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, wes);
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFAA || rsp_err !== 1'b0) begin
                errors++; $display("FAIL bp_hold: got valid=%b rdata=%h err=%b want 1/ffffffaa/0",
                                   rsp_valid, rsp_rdata, rsp_err);
            end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, wes, we0;
        we0        = we_cnt;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000055;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b want 0", mem_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (we_cnt - we0 !== 0) begin errors++; $display("FAIL rst_mid_writes: got %0d want 0", we_cnt - we0); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, wes);
        checks++;
        if (rsp_rdata !== 32'h11AA3344) begin errors++; $display("FAIL rst_mid_mem: got %h want 11aa3344", rsp_rdata); end
        consume();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
